// File: rtl/regfile_bypass_sb_if.sv
// regfile_bypass_sb_if
//   Bundles the decode-side (read/issue), writeback-side (write) and
//   pipeline-control (flush) signals of the bypassing register file.
//   master : pipeline side, drives indices/data/control, observes read data
//            and hazard flags.
//   slave  : the register file itself.
//   Signals:
//     WEN, RD_SEL, WB_DATA        writeback port
//     RS_SEL, SRC_DOUT, RS_BUSY   NUM_READ packed read ports
//     ISSUE_VALID, ISSUE_RD       destination marking at issue
//     FLUSH                       drop all pending-write marks
//     BUSY_VEC                    raw scoreboard state
interface regfile_bypass_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                             WEN;
  logic [ADDR_WIDTH-1:0]            RD_SEL;
  logic [DATA_WIDTH-1:0]            WB_DATA;
  logic [NUM_READ*ADDR_WIDTH-1:0]   RS_SEL;
  logic [NUM_READ*DATA_WIDTH-1:0]   SRC_DOUT;
  logic [NUM_READ-1:0]              RS_BUSY;
  logic                             ISSUE_VALID;
  logic [ADDR_WIDTH-1:0]            ISSUE_RD;
  logic                             FLUSH;
  logic [(2**ADDR_WIDTH)-1:0]       BUSY_VEC;

  modport master (
    output WEN, RD_SEL, WB_DATA, RS_SEL, ISSUE_VALID, ISSUE_RD, FLUSH,
    input  SRC_DOUT, RS_BUSY, BUSY_VEC
  );

  modport slave (
    input  WEN, RD_SEL, WB_DATA, RS_SEL, ISSUE_VALID, ISSUE_RD, FLUSH,
    output SRC_DOUT, RS_BUSY, BUSY_VEC
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb
//   Integer register file with NUM_READ combinational read ports, one
//   synchronous write port, write-to-read bypass and a per-register
//   scoreboard of pending writes for RAW hazard detection at decode.
//   Ports:
//     CLK    clock, all state updates on the rising edge
//     RESET  synchronous active-high reset (registers and busy bits to 0)
//     rf     regfile_bypass_sb_if.slave bundle (write, read, issue, flush,
//            scoreboard debug vector)
//   ZERO_REG=1 makes index 0 read as zero, drops writes to it and keeps it
//   permanently not-busy.
module regfile_bypass_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  regfile_bypass_sb_if.slave    rf
);

  localparam int              DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit              ZR       = (ZERO_REG != 0);
  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]          regs_r [DEPTH];
  logic [DEPTH-1:0]               busy_r;
  logic [DEPTH-1:0]               busy_nxt_s;
  logic [DEPTH-1:0]               clr_mask_s;
  logic [DEPTH-1:0]               set_mask_s;
  logic                           wr_ok_s;
  logic                           issue_ok_s;
  logic [ADDR_WIDTH-1:0]          idx_s [NUM_READ];
  logic [NUM_READ*DATA_WIDTH-1:0] dout_s;
  logic [NUM_READ-1:0]            rs_busy_s;

  // A write or issue aimed at a hardwired-zero x0 has no effect at all.
  assign wr_ok_s    = rf.WEN && !(ZR && (rf.RD_SEL == {ADDR_WIDTH{1'b0}}));
  assign issue_ok_s = rf.ISSUE_VALID && !(ZR && (rf.ISSUE_RD == {ADDR_WIDTH{1'b0}}));

  // Scoreboard next state: flush beats everything; otherwise set is applied
  // after clear so a same-cycle issue to the completing index stays busy.
  always_comb begin
    clr_mask_s = wr_ok_s    ? (ONE_HOT0 << rf.RD_SEL)   : {DEPTH{1'b0}};
    set_mask_s = issue_ok_s ? (ONE_HOT0 << rf.ISSUE_RD) : {DEPTH{1'b0}};
    if (rf.FLUSH) begin
      busy_nxt_s = {DEPTH{1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end
    if (ZR) begin
      busy_nxt_s = busy_nxt_s & ~ONE_HOT0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // Storage and scoreboard update; reset discards that cycle's write/issue.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        regs_r[rf.RD_SEL] <= rf.WB_DATA;
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Unpack the per-port read indices.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      idx_s[k] = rf.RS_SEL[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Read ports: zero register, then same-cycle writeback bypass, then
  // storage. A bypass hit also satisfies the hazard, so busy is masked.
  always_comb begin
    dout_s    = {(NUM_READ*DATA_WIDTH){1'b0}};
    rs_busy_s = {NUM_READ{1'b0}};
    for (int k = 0; k < NUM_READ; k++) begin
      if (ZR && (idx_s[k] == {ADDR_WIDTH{1'b0}})) begin
        dout_s[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        rs_busy_s[k]                       = 1'b0;
      end else if (wr_ok_s && (rf.RD_SEL == idx_s[k])) begin
        dout_s[k*DATA_WIDTH +: DATA_WIDTH] = rf.WB_DATA;
        rs_busy_s[k]                       = 1'b0;
      end else begin
        dout_s[k*DATA_WIDTH +: DATA_WIDTH] = regs_r[idx_s[k]];
        rs_busy_s[k]                       = busy_r[idx_s[k]];
      end
    end
  end

  assign rf.SRC_DOUT = dout_s;
  assign rf.RS_BUSY  = rs_busy_s;
  assign rf.BUSY_VEC = busy_r;

endmodule
